// File: rtl/requant_stream_pc.sv
// Per-channel requantizer: 3-stage elastic pipeline (multiply, round/shift, ReLU/zp/clamp)
// with per-lane scale/shift/zero-point and a saturating clamp counter.
module requant_stream_pc #(
  parameter int LANES   = 4,
  parameter int ACC_W   = 32,
  parameter int SCALE_W = 16,
  parameter int SHIFT_W = 6,
  parameter int OUT_W   = 8,
  parameter int CNT_W   = 16,
  localparam int LN_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ACC_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_data,
  input  logic                     cfg_we,
  input  logic [LN_W-1:0]          cfg_lane,
  input  logic [SCALE_W-1:0]       cfg_scale,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic [OUT_W-1:0]         cfg_zp,
  input  logic                     round_en,
  input  logic                     relu_en,
  input  logic                     out_unsigned,
  input  logic                     clear_stats,
  output logic [CNT_W-1:0]         sat_count
);

  localparam int PROD_W = ACC_W + SCALE_W + 1;
  localparam int SH_W   = PROD_W + 1;
  localparam int SUM_W  = SH_W + 1;
  localparam int PC_W   = $clog2(LANES + 1);

  // One bit of headroom over the product so the rounding bias can never overflow.
  function automatic logic signed [SH_W-1:0] round_shift(input logic signed [PROD_W-1:0] p,
                                                        input logic [SHIFT_W-1:0] sh,
                                                        input logic rnd);
    logic signed [SH_W-1:0] ext;
    logic signed [SH_W-1:0] bias;
    ext = $signed({p[PROD_W-1], p});
    if (sh == '0) return ext;
    if (int'(sh) >= SH_W) return {SH_W{p[PROD_W-1]}};
    bias = rnd ? (SH_W'(1) <<< (sh - SHIFT_W'(1))) : '0;
    return (ext + bias) >>> sh;
  endfunction

  // Returns {sat_flag, clamped_value}.
  function automatic logic [OUT_W:0] clamp_out(input logic signed [SH_W-1:0] v,
                                              input logic [OUT_W-1:0] zp,
                                              input logic relu,
                                              input logic uns);
    logic signed [SUM_W-1:0] s;
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    s  = (relu && v < 0) ? '0 : $signed({v[SH_W-1], v});
    s  = s + $signed({{(SUM_W-OUT_W){zp[OUT_W-1]}}, zp});
    hi = uns ? $signed({{(SUM_W-OUT_W){1'b0}}, {OUT_W{1'b1}}})
             : $signed({{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    lo = uns ? '0 : $signed({{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});
    if (s > hi) return {1'b1, hi[OUT_W-1:0]};
    if (s < lo) return {1'b1, lo[OUT_W-1:0]};
    return {1'b0, s[OUT_W-1:0]};
  endfunction

  logic [SCALE_W-1:0] scale_q [LANES], scale_d [LANES];
  logic [SHIFT_W-1:0] shcfg_q [LANES], shcfg_d [LANES];
  logic [OUT_W-1:0]   zpcfg_q [LANES], zpcfg_d [LANES];

  logic vld_p1_q, vld_p1_d, rnd_p1_q, rnd_p1_d, relu_p1_q, relu_p1_d, uns_p1_q, uns_p1_d;
  logic signed [PROD_W-1:0] prod_p1_q [LANES], prod_p1_d [LANES];
  logic [SHIFT_W-1:0]       shift_p1_q [LANES], shift_p1_d [LANES];
  logic [OUT_W-1:0]         zp_p1_q [LANES], zp_p1_d [LANES];

  logic vld_p2_q, vld_p2_d, relu_p2_q, relu_p2_d, uns_p2_q, uns_p2_d;
  logic signed [SH_W-1:0]   val_p2_q [LANES], val_p2_d [LANES];
  logic [OUT_W-1:0]         zp_p2_q [LANES], zp_p2_d [LANES];

  logic                     vld_p3_q, vld_p3_d;
  logic [LANES*OUT_W-1:0]   data_p3_q, data_p3_d;
  logic [LANES-1:0]         sat_p3_q, sat_p3_d;
  logic [CNT_W-1:0]         sat_count_q, sat_count_d;

  logic rdy_p1, rdy_p2, rdy_p3;
  logic [PC_W-1:0] pc;
  logic [CNT_W:0]  cnt_sum;

  assign rdy_p3    = !vld_p3_q || out_ready;
  assign rdy_p2    = !vld_p2_q || rdy_p3;
  assign rdy_p1    = !vld_p1_q || rdy_p2;
  assign in_ready  = rdy_p1;
  assign out_valid = vld_p3_q;
  assign out_data  = data_p3_q;
  assign sat_count = sat_count_q;

  always_comb begin
    vld_p1_d = vld_p1_q; rnd_p1_d = rnd_p1_q; relu_p1_d = relu_p1_q; uns_p1_d = uns_p1_q;
    vld_p2_d = vld_p2_q; relu_p2_d = relu_p2_q; uns_p2_d = uns_p2_q;
    vld_p3_d = vld_p3_q; data_p3_d = data_p3_q; sat_p3_d = sat_p3_q;
    sat_count_d = sat_count_q;
    pc = '0;
    cnt_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      scale_d[i] = scale_q[i]; shcfg_d[i] = shcfg_q[i]; zpcfg_d[i] = zpcfg_q[i];
      prod_p1_d[i] = prod_p1_q[i]; shift_p1_d[i] = shift_p1_q[i]; zp_p1_d[i] = zp_p1_q[i];
      val_p2_d[i] = val_p2_q[i]; zp_p2_d[i] = zp_p2_q[i];
      if (cfg_we && cfg_lane == LN_W'(i)) begin
        scale_d[i] = cfg_scale; shcfg_d[i] = cfg_shift; zpcfg_d[i] = cfg_zp;
      end
    end

    // Stage 1: multiply; config and mode bits are frozen into the beat here.
    if (rdy_p1) vld_p1_d = in_valid;
    if (rdy_p1 && in_valid) begin
      rnd_p1_d = round_en; relu_p1_d = relu_en; uns_p1_d = out_unsigned;
      for (int i = 0; i < LANES; i++) begin
        prod_p1_d[i]  = PROD_W'($signed(in_data[i*ACC_W +: ACC_W])) *
                        PROD_W'($signed({1'b0, scale_q[i]}));
        shift_p1_d[i] = shcfg_q[i];
        zp_p1_d[i]    = zpcfg_q[i];
      end
    end

    // Stage 2: round and shift.
    if (rdy_p2) vld_p2_d = vld_p1_q;
    if (rdy_p2 && vld_p1_q) begin
      relu_p2_d = relu_p1_q; uns_p2_d = uns_p1_q;
      for (int i = 0; i < LANES; i++) begin
        val_p2_d[i] = round_shift(prod_p1_q[i], shift_p1_q[i], rnd_p1_q);
        zp_p2_d[i]  = zp_p1_q[i];
      end
    end

    // Stage 3: ReLU, zero point, clamp.
    if (rdy_p3) vld_p3_d = vld_p2_q;
    if (rdy_p3 && vld_p2_q) begin
      for (int i = 0; i < LANES; i++)
        {sat_p3_d[i], data_p3_d[i*OUT_W +: OUT_W]} =
          clamp_out(val_p2_q[i], zp_p2_q[i], relu_p2_q, uns_p2_q);
    end

    for (int i = 0; i < LANES; i++) pc = pc + PC_W'(sat_p3_q[i]);
    cnt_sum = {1'b0, sat_count_q} + (CNT_W+1)'(pc);
    if (vld_p3_q && out_ready) sat_count_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    if (clear_stats) sat_count_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1_q <= 1'b0; rnd_p1_q <= 1'b0; relu_p1_q <= 1'b0; uns_p1_q <= 1'b0;
      vld_p2_q <= 1'b0; relu_p2_q <= 1'b0; uns_p2_q <= 1'b0;
      vld_p3_q <= 1'b0; data_p3_q <= '0; sat_p3_q <= '0;
      sat_count_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        scale_q[i] <= SCALE_W'(1); shcfg_q[i] <= '0; zpcfg_q[i] <= '0;
      end
    end else begin
      vld_p1_q <= vld_p1_d; rnd_p1_q <= rnd_p1_d; relu_p1_q <= relu_p1_d; uns_p1_q <= uns_p1_d;
      vld_p2_q <= vld_p2_d; relu_p2_q <= relu_p2_d; uns_p2_q <= uns_p2_d;
      vld_p3_q <= vld_p3_d; data_p3_q <= data_p3_d; sat_p3_q <= sat_p3_d;
      sat_count_q <= sat_count_d;
      for (int i = 0; i < LANES; i++) begin
        scale_q[i] <= scale_d[i]; shcfg_q[i] <= shcfg_d[i]; zpcfg_q[i] <= zpcfg_d[i];
      end
    end
  end

  // Datapath registers carry no reset; their valids guard them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      prod_p1_q[i] <= prod_p1_d[i]; shift_p1_q[i] <= shift_p1_d[i]; zp_p1_q[i] <= zp_p1_d[i];
      val_p2_q[i]  <= val_p2_d[i];  zp_p2_q[i]    <= zp_p2_d[i];
    end
  end

endmodule

// File: tb/tb_requant_stream_pc.sv
// Bench for requant_stream_pc: directed test-plan cases plus randomized traffic against
// an arithmetic reference model with a scoreboard queue.
module tb_requant_stream_pc;

  localparam int WIDE = 32 + 16 + 2;

  logic         clk, reset_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data;
  logic [31:0]  out_data;
  logic         cfg_we;
  logic [1:0]   cfg_lane;
  logic [15:0]  cfg_scale;
  logic [5:0]   cfg_shift;
  logic [7:0]   cfg_zp;
  logic         round_en, relu_en, out_unsigned, clear_stats;
  logic [15:0]  sat_count;

  requant_stream_pc dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
    .cfg_zp(cfg_zp), .round_en(round_en), .relu_en(relu_en), .out_unsigned(out_unsigned),
    .clear_stats(clear_stats), .sat_count(sat_count)
  );

  typedef struct { logic [31:0] d; int ns; } exp_t;

  int          n_vec = 0, n_err = 0, cyc = 0;
  exp_t        exp_q[$];
  logic [7:0]  rx_log[$];
  int          m_scale[4], m_shift[4], m_zp[4];
  int          m_cnt = 0;
  logic        hold_v = 0;
  logic [31:0] hold_d = '0;

  initial clk = 0;
  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin m_scale[i] = 1; m_shift[i] = 0; m_zp[i] = 0; end
    m_cnt = 0;
  endfunction

  // Reference: y = clamp(relu(round(x*scale / 2^shift)) + zp), done in 64-bit integers.
  function automatic exp_t model(input logic [127:0] d, input logic rnd, input logic relu,
                                 input logic uns);
    exp_t e;
    e.d = '0; e.ns = 0;
    for (int i = 0; i < 4; i++) begin
      longint a, p, v, b, lo, hi;
      logic [31:0] w;
      logic [63:0] vv;
      w = d[i*32 +: 32];
      a = longint'($signed(w));
      p = a * longint'(m_scale[i]);
      if (m_shift[i] == 0) v = p;
      else if (m_shift[i] >= WIDE) v = (p < 0) ? -1 : 0;
      else begin
        b = rnd ? (longint'(1) <<< (m_shift[i] - 1)) : 0;
        v = (p + b) >>> m_shift[i];
      end
      if (relu && v < 0) v = 0;
      v = v + m_zp[i];
      lo = uns ? 0 : -128;
      hi = uns ? 255 : 127;
      if (v > hi) begin v = hi; e.ns++; end
      else if (v < lo) begin v = lo; e.ns++; end
      vv = v;
      e.d[i*8 +: 8] = vv[7:0];
    end
    return e;
  endfunction

  function automatic logic [127:0] p4(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic logic [31:0] o4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Scoreboard: everything is observed at the falling edge, between driver updates.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      chk("sat_count", 64'(sat_count), 64'(m_cnt));
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_stable", 64'(out_data), 64'(hold_d));
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 64'(out_data), 64'hdead_beef_0000);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.d));
          rx_log.push_back(out_data[7:0]);
          m_cnt = (m_cnt + e.ns > 65535) ? 65535 : m_cnt + e.ns;
        end
      end
      if (clear_stats) m_cnt = 0;
      if (in_valid && in_ready) exp_q.push_back(model(in_data, round_en, relu_en, out_unsigned));
      if (cfg_we) begin
        m_scale[cfg_lane] = int'(cfg_scale);
        m_shift[cfg_lane] = int'(cfg_shift);
        m_zp[cfg_lane]    = int'($signed(cfg_zp));
      end
    end
  end

  task automatic send(input logic [127:0] d);
    in_data = d; in_valid = 1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin @(posedge clk); #1; in_valid = 0; return; end
    end
    chk("send_timeout", 64'd0, 64'd1);
    in_valid = 0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] exp);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk(name, 64'(out_data), 64'(exp));
        @(posedge clk); #1;
        return;
      end
    end
    chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic cfg_write(input int lane, input int scale, input int shift, input int zp);
    cfg_we = 1; cfg_lane = 2'(lane); cfg_scale = 16'(scale); cfg_shift = 6'(shift); cfg_zp = 8'(zp);
    @(posedge clk); #1;
    cfg_we = 0;
  endtask

  function automatic logic [31:0] rnd_acc();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'(int'($urandom_range(0, 4000)) - 2000);
      2: return 32'(int'($urandom_range(0, 400)) - 200);
      default: return $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7fff_ffff;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int c0;
    reset_n = 0; in_valid = 0; in_data = '0; out_ready = 1; cfg_we = 0; cfg_lane = 0;
    cfg_scale = 0; cfg_shift = 0; cfg_zp = 0; round_en = 0; relu_en = 0; out_unsigned = 0;
    clear_stats = 0;
    m_reset();
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_sat_count", 64'(sat_count), 64'd0);
    #11 reset_n = 1;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 1. identity and latency
    send(p4(100, -100, 127, -128));
    chk("lat_edge1", 64'(out_valid), 64'd0);
    @(posedge clk); #1; chk("lat_edge2", 64'(out_valid), 64'd0);
    @(posedge clk); #1; chk("lat_edge3", 64'(out_valid), 64'd1);
    chk("identity", 64'(out_data), 64'(o4(100, -100, 127, -128)));
    @(posedge clk); #1; chk("identity_sat", 64'(sat_count), 64'd0);

    // 2. rounding
    for (int i = 0; i < 4; i++) cfg_write(i, 1, 4, 0);
    round_en = 0; send(p4(1600, 1608, -1608, 8));
    expect_out("trunc", o4(100, 100, -101, 0));
    round_en = 1; send(p4(1600, 1608, -1608, 8));
    expect_out("round", o4(100, 101, -100, 1));
    round_en = 0;

    // 3. saturation
    for (int i = 0; i < 4; i++) cfg_write(i, 2, 0, 0);
    send(p4(3200, -3200, 63, -65));
    expect_out("sat_signed", o4(127, -128, 126, -128));
    chk("sat_cnt3", 64'(sat_count), 64'd3);
    out_unsigned = 1; send(p4(3200, -3200, 63, -65));
    expect_out("sat_unsigned", o4(255, 0, 126, 0));
    chk("sat_cnt6", 64'(sat_count), 64'd6);
    out_unsigned = 0;
    clear_stats = 1; @(posedge clk); #1; clear_stats = 0;
    chk("sat_clear", 64'(sat_count), 64'd0);

    // 4. per-lane config and relu
    cfg_write(0, 1, 0, 0); cfg_write(1, 1, 1, 0); cfg_write(2, 1, 2, 10); cfg_write(3, 1, 3, 0);
    send(p4(64, 64, 64, 64));
    expect_out("per_lane", o4(64, 32, 26, 8));
    relu_en = 1; send(p4(-64, -64, -64, -64));
    expect_out("relu", o4(0, 0, 10, 0));
    relu_en = 0;

    // 5. backpressure and throughput
    for (int i = 0; i < 4; i++) cfg_write(i, 1, 0, 0);
    rx_log.delete();
    out_ready = 0;
    for (int k = 1; k <= 3; k++) send(p4(k, k, k, k));
    in_data = p4(4, 4, 4, 4); in_valid = 1;
    repeat (4) begin @(negedge clk); chk("bp_in_ready", 64'(in_ready), 64'd0); end
    @(posedge clk); #1; out_ready = 1;
    send(p4(4, 4, 4, 4)); send(p4(5, 5, 5, 5));
    for (int t = 0; t < 20 && rx_log.size() < 5; t++) @(posedge clk);
    #1 chk("bp_count", 64'(rx_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < rx_log.size(); k++) chk("bp_order", 64'(rx_log[k]), 64'(k + 1));
    c0 = cyc;
    for (int k = 0; k < 20; k++) send(p4(k, -k, 3 * k, 100 - k));
    chk("stream_cycles", 64'(cyc - c0), 64'd20);
    repeat (5) @(posedge clk); #1;

    // 6. config race, then reset with beats in flight
    cfg_we = 1; cfg_lane = 0; cfg_scale = 1; cfg_shift = 1; cfg_zp = 0;
    in_data = p4(8, 8, 8, 8); in_valid = 1;
    @(negedge clk); chk("race_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1; cfg_we = 0; in_valid = 0;
    expect_out("race_old_cfg", o4(8, 8, 8, 8));
    send(p4(8, 8, 8, 8));
    expect_out("race_new_cfg", o4(4, 8, 8, 8));

    out_ready = 0;
    send(p4(7, 7, 7, 7)); send(p4(9, 9, 9, 9));
    @(posedge clk); #3;
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    reset_n = 0;
    #1 chk("reset_drop_valid", 64'(out_valid), 64'd0);
    exp_q.delete(); hold_v = 0; m_reset();
    out_ready = 1;
    repeat (2) @(negedge clk);
    #2 reset_n = 1;
    repeat (5) begin @(negedge clk); chk("post_reset_idle", 64'(out_valid), 64'd0); end
    @(posedge clk); #1;
    send(p4(5, 5, 5, 5));
    expect_out("reset_cfg_default", o4(5, 5, 5, 5));

    // random traffic
    for (int c = 0; c < 800; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = {rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc()};
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_lane = 2'($urandom_range(0, 3));
      cfg_scale = $urandom_range(0, 1) ? 16'($urandom_range(0, 4)) : 16'($urandom);
      cfg_shift = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 10));
      cfg_zp = 8'($urandom);
      round_en = 1'($urandom); relu_en = 1'($urandom); out_unsigned = 1'($urandom);
      clear_stats = ($urandom_range(0, 31) == 0);
      @(posedge clk); #1;
    end
    in_valid = 0; cfg_we = 0; clear_stats = 0; out_ready = 1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
    #1 chk("drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
